// File: rtl/uart_pkg.sv
// uart_pkg: frame constants, receiver FSM states and parity helper shared by the UART tx and rx sides
package uart_pkg;
  typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} rx_state_t;
  localparam int FRAME_BITS = 11;
  localparam int PARITY_IDX = 8;
  function automatic logic calc_parity(input logic [PARITY_IDX:0] bits, input logic odd);
    return ^bits ^ odd;
  endfunction
endpackage

// File: rtl/rx_sync_fifo.sv
// rx_sync_fifo: show-ahead FIFO; level is the authoritative count, pointers wrap modulo DEPTH
module rx_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH:0]           din,
  output logic [DATA_WIDTH:0]           dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(FIFO_DEPTH);
  assign do_pop = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge baud_clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge baud_clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/rx_deframer_fifo.sv
// rx_deframer_fifo: UART frame receiver feeding a show-ahead FIFO.
// Define RX_PARITY_DROP_EN to discard bad-parity frames and expose a parity_drop pulse.
module rx_deframer_fifo import uart_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter bit PARITY_ODD = 0
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          parity_err,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          overflow
`ifdef RX_PARITY_DROP_EN
  ,
  output logic                          parity_drop
`endif
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  rx_state_t state, state_n;
  logic [CW-1:0] bit_cnt;
  logic [DATA_WIDTH:0] shift_reg, head;
  logic push, fifo_push, perr, perr_store;
  assign perr = calc_parity(shift_reg, PARITY_ODD);
`ifdef RX_PARITY_DROP_EN
  assign fifo_push = push & ~perr;
  assign perr_store = 1'b0;
`else
  assign fifo_push = push;
  assign perr_store = perr;
`endif
  always_comb begin
    state_n = state;
    push = 1'b0;
    case (state)
      IDLE:      state_n = serial_in ? IDLE : DATA;
      DATA:      state_n = bit_cnt == LAST ? STOP : DATA;
      STOP: begin
        state_n = serial_in ? IDLE : WAIT_IDLE;
        push = serial_in;
      end
      WAIT_IDLE: state_n = serial_in ? IDLE : WAIT_IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge baud_clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift_reg <= '0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= state == DATA ? bit_cnt + 1'b1 : '0;
      if (state == DATA) shift_reg[bit_cnt] <= serial_in;
      frame_err <= state == STOP && !serial_in;
      if (fifo_push && rx_full && !rd_en) overflow <= 1'b1;
    end
`ifdef RX_PARITY_DROP_EN
  always_ff @(posedge baud_clk or posedge rst)
    if (rst) parity_drop <= 1'b0;
    else parity_drop <= push & perr;
`endif
  rx_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .baud_clk(baud_clk),
    .rst(rst),
    .push(fifo_push),
    .pop(rd_en),
    .din({perr_store, shift_reg[DATA_WIDTH-1:0]}),
    .dout(head),
    .empty(rx_empty),
    .full(rx_full),
    .level(level)
  );
  assign data_out = head[DATA_WIDTH-1:0];
  assign parity_err = head[DATA_WIDTH];
  assign rx_ready = ~rx_full;
endmodule

// File: tb/tb_rx_deframer_fifo.sv
// tb_rx_deframer_fifo: directed frames with a scoreboard queue checked by a read-side monitor
module tb_rx_deframer_fifo;
  localparam bit PODD = 1'b0;
  logic baud_clk = 0, rst = 1, serial_in = 1, rd_en = 0;
  logic [7:0] data_out;
  logic parity_err, rx_empty, rx_full, rx_ready, frame_err, overflow;
  logic [4:0] level;
  logic [8:0] sb[$];
  int checks = 0, errors = 0, ferr_cnt = 0, pdrop_cnt = 0;
`ifdef RX_PARITY_DROP_EN
  logic parity_drop;
`endif

  rx_deframer_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY_ODD(PODD)) dut (
    .baud_clk(baud_clk), .rst(rst), .serial_in(serial_in), .rd_en(rd_en),
    .data_out(data_out), .parity_err(parity_err), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_ready(rx_ready), .level(level),
    .frame_err(frame_err), .overflow(overflow)
`ifdef RX_PARITY_DROP_EN
    , .parity_drop(parity_drop)
`endif
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge baud_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par = 0, input logic stop = 1,
                      input logic pop_stop = 0);
    logic [10:0] f;
    f = {stop, ^d ^ PODD ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      serial_in = f[i];
      rd_en = (i == 10) ? pop_stop : 1'b0;
      tick();
    end
    serial_in = 1;
    rd_en = 0;
  endtask

  task automatic drain();
    rd_en = 1;
    for (int i = 0; i < 40 && !rx_empty; i++) tick();
    rd_en = 0;
    chk("drain_empty", rx_empty, 1);
    chk("sb_consumed", sb.size(), 0);
  endtask

  task automatic apply_reset();
    rst = 1;
    serial_in = 1;
    rd_en = 0;
    tick(2);
    rst = 0;
    sb.delete();
    tick();
  endtask

  // Read-side monitor: every accepted pop must match the oldest expected entry
  initial forever begin
    @(negedge baud_clk);
    if (frame_err) ferr_cnt++;
`ifdef RX_PARITY_DROP_EN
    if (parity_drop) pdrop_cnt++;
`endif
    if (!rst && rd_en && !rx_empty) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got=%0h expected=none", {parity_err, data_out});
      end else chk("pop_data", {parity_err, data_out}, sb.pop_front());
    end
  end

  initial begin
    int f0, p0;
    tick(2);
    chk("rst_empty", rx_empty, 1);
    chk("rst_full", rx_full, 0);
    chk("rst_ready", rx_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_data", data_out, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 0;
    tick(2);

    send(8'hA5);
    sb.push_back({1'b0, 8'hA5});
    chk("a5_empty", rx_empty, 0);
    chk("a5_data", data_out, 8'hA5);
    chk("a5_perr", parity_err, 0);
    chk("a5_level", level, 1);

    p0 = pdrop_cnt;
    send(8'h3C, 1);
    tick(2);
`ifdef RX_PARITY_DROP_EN
    chk("3c_level", level, 1);
    chk("3c_pdrop", pdrop_cnt - p0, 1);
`else
    sb.push_back({1'b1, 8'h3C});
    chk("3c_level", level, 2);
    chk("3c_pdrop", pdrop_cnt - p0, 0);
`endif
    drain();

    f0 = ferr_cnt;
    send(8'h55, 0, 0);
    serial_in = 0;
    tick(5);
    serial_in = 1;
    tick();
    send(8'h12);
    sb.push_back({1'b0, 8'h12});
    tick();
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_level", level, 1);
    chk("brk_data", data_out, 8'h12);
    drain();

    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      sb.push_back({1'b0, 8'(i)});
    end
    chk("fill_full", rx_full, 1);
    chk("fill_ready", rx_ready, 0);
    chk("fill_level", level, 16);
    chk("fill_ovf0", overflow, 0);
    send(8'hFF);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    chk("ovf_head", data_out, 8'h00);
    drain();
    chk("ovf_sticky", overflow, 1);

    apply_reset();
    for (int i = 0; i < 16; i++) begin
      send(8'(i));
      sb.push_back({1'b0, 8'(i)});
    end
    send(8'h77, 0, 1, 1);
    sb.push_back({1'b0, 8'h77});
    chk("pp_level", level, 16);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", data_out, 8'h01);
    drain();

    serial_in = 0;
    tick();
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'(8'h99 >> i);
      tick();
    end
    serial_in = 1'(8'h99 >> 4);
    rst = 1;
    tick();
    rst = 0;
    serial_in = 1;
    sb.delete();
    tick(2);
    chk("mid_rst_level", level, 0);
    send(8'h42);
    sb.push_back({1'b0, 8'h42});
    chk("mid_level", level, 1);
    chk("mid_data", data_out, 8'h42);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
